// File: rtl/load_pkg.sv
// Shared load-path types: load-type encodings, FSM states and size/type helpers.
package load_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LD  = 3'b011,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101,
    LT_LWU = 3'b110
  } load_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_WAIT0,
    ST_RD1,
    ST_WAIT1,
    ST_DONE
  } load_state_e;

  function automatic logic [3:0] access_bytes(input load_type_e t);
    case (t)
      LT_LB, LT_LBU: return 4'd1;
      LT_LH, LT_LHU: return 4'd2;
      LT_LD:         return 4'd8;
      default:       return 4'd4;
    endcase
  endfunction

  // LD has no meaning on a 32-bit datapath and unknown codes fall back to LW.
  function automatic load_type_e norm_type(input logic [2:0] raw, input int unsigned xlen);
    case (raw)
      3'b000:  return LT_LB;
      3'b001:  return LT_LH;
      3'b011:  return (xlen == 64) ? LT_LD : LT_LW;
      3'b100:  return LT_LBU;
      3'b101:  return LT_LHU;
      3'b110:  return LT_LWU;
      default: return LT_LW;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_merge.sv
// Combinational merge of two read words, byte shift by offset and sign/zero extension.
module load_ext_merge
  import load_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              i_word0,
  input  logic [XLEN-1:0]              i_word1,
  input  logic [$clog2(XLEN/8)-1:0]    i_offset,
  input  load_type_e                   i_type,
  output logic [XLEN-1:0]              o_result
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = XLEN'({i_word1, i_word0} >> {i_offset, 3'b000});

  always_comb begin
    o_result = '0;
    case (i_type)
      LT_LB:   o_result = XLEN'($signed(w_shifted[7:0]));
      LT_LBU:  o_result = XLEN'(w_shifted[7:0]);
      LT_LH:   o_result = XLEN'($signed(w_shifted[15:0]));
      LT_LHU:  o_result = XLEN'(w_shifted[15:0]);
      LT_LWU:  o_result = XLEN'(w_shifted[31:0]);
      LT_LD:   o_result = w_shifted;
      default: o_result = XLEN'($signed(w_shifted[31:0]));
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word reads per load and returns the extended result.
module load_align_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [2:0]      req_type,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [31:0]     mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_misalign
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  load_state_e     r_state;
  load_type_e      r_type;
  logic [OFFW-1:0] r_off;
  logic            r_cross;
  logic [XLEN-1:0] r_word0;
  logic [XLEN-1:0] r_word1;
  logic            r_mem_req;
  logic [31:0]     r_mem_addr;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_misalign;

  load_type_e      w_req_type;
  logic [OFFW-1:0] w_req_off;
  logic            w_req_cross;
  logic [31:0]     w_req_base;
  logic [XLEN-1:0] w_word0;
  logic [XLEN-1:0] w_word1;
  logic [XLEN-1:0] w_result;

  assign w_req_type  = norm_type(req_type, XLEN);
  assign w_req_off   = req_addr[OFFW-1:0];
  assign w_req_cross = (32'(w_req_off) + 32'(access_bytes(w_req_type))) > NB;
  assign w_req_base  = {req_addr[31:OFFW], {OFFW{1'b0}}};

  // Bypass the arriving word so the result registers on the same edge it is captured.
  assign w_word0 = (r_state == ST_WAIT0) ? mem_rdata : r_word0;
  assign w_word1 = (r_state == ST_WAIT1) ? mem_rdata : r_word1;

  load_ext_merge #(.XLEN(XLEN)) u_merge (
    .i_word0  (w_word0),
    .i_word1  (w_word1),
    .i_offset (r_off),
    .i_type   (r_type),
    .o_result (w_result)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= ST_IDLE;
      r_type         <= LT_LB;
      r_off          <= '0;
      r_cross        <= 1'b0;
      r_word0        <= '0;
      r_word1        <= '0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_type     <= w_req_type;
          r_off      <= w_req_off;
          r_cross    <= w_req_cross;
          r_mem_addr <= w_req_base;
          if (w_req_cross && !SPLIT_EN) begin
            r_state        <= ST_DONE;
            r_rsp_valid    <= 1'b1;
            r_rsp_data     <= '0;
            r_rsp_misalign <= 1'b1;
          end else begin
            r_state   <= ST_RD0;
            r_mem_req <= 1'b1;
          end
        end
        ST_RD0: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= ST_WAIT0;
        end
        ST_WAIT0: if (mem_rvalid) begin
          r_word0 <= mem_rdata;
          if (r_cross) begin
            r_state    <= ST_RD1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_mem_addr + 32'(NB);
          end else begin
            r_state        <= ST_DONE;
            r_rsp_valid    <= 1'b1;
            r_rsp_data     <= w_result;
            r_rsp_misalign <= 1'b0;
          end
        end
        ST_RD1: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= ST_WAIT1;
        end
        ST_WAIT1: if (mem_rvalid) begin
          r_word1        <= mem_rdata;
          r_state        <= ST_DONE;
          r_rsp_valid    <= 1'b1;
          r_rsp_data     <= w_result;
          r_rsp_misalign <= 1'b0;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_misalign = r_rsp_misalign;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three configurations checked against a byte-level load model.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic        req_valid, mem_gnt, mem_rvalid;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [63:0] mem_rdata;
  logic [31:0] seed;

  logic        rdy [3];
  logic        mreq[3];
  logic [31:0] maddr[3];
  logic        rv  [3];
  logic        mis [3];
  logic [31:0] rd32[2];
  logic [63:0] rd64;
  logic [2:0]  vld_g, gnt_g, rvl_g;

  logic        o_ready, o_mem_req, o_rsp_valid, o_rsp_mis;
  logic [31:0] o_mem_addr;
  logic [63:0] o_rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vld_g[k] = req_valid  && (sel == k);
      gnt_g[k] = mem_gnt    && (sel == k);
      rvl_g[k] = mem_rvalid && (sel == k);
    end
  end

  always_comb begin
    o_ready     = rdy[sel];
    o_mem_req   = mreq[sel];
    o_mem_addr  = maddr[sel];
    o_rsp_valid = rv[sel];
    o_rsp_mis   = mis[sel];
    case (sel)
      0:       o_rsp_data = {32'h0, rd32[0]};
      1:       o_rsp_data = {32'h0, rd32[1]};
      default: o_rsp_data = rd64;
    endcase
  end

  load_align_unit #(.XLEN(32), .SPLIT_EN(1'b1)) u_dut32 (
    .CLK(clk), .RST_N(rst_n), .req_valid(vld_g[0]), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_type(req_type), .mem_req(mreq[0]), .mem_gnt(gnt_g[0]),
    .mem_addr(maddr[0]), .mem_rvalid(rvl_g[0]), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rv[0]), .rsp_data(rd32[0]), .rsp_misalign(mis[0]));

  load_align_unit #(.XLEN(32), .SPLIT_EN(1'b0)) u_dut32n (
    .CLK(clk), .RST_N(rst_n), .req_valid(vld_g[1]), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_type(req_type), .mem_req(mreq[1]), .mem_gnt(gnt_g[1]),
    .mem_addr(maddr[1]), .mem_rvalid(rvl_g[1]), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rv[1]), .rsp_data(rd32[1]), .rsp_misalign(mis[1]));

  load_align_unit #(.XLEN(64), .SPLIT_EN(1'b1)) u_dut64 (
    .CLK(clk), .RST_N(rst_n), .req_valid(vld_g[2]), .req_ready(rdy[2]),
    .req_addr(req_addr), .req_type(req_type), .mem_req(mreq[2]), .mem_gnt(gnt_g[2]),
    .mem_addr(maddr[2]), .mem_rvalid(rvl_g[2]), .mem_rdata(mem_rdata),
    .rsp_valid(rv[2]), .rsp_data(rd64), .rsp_misalign(mis[2]));

  // Byte-addressed memory image used for randomized loads.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    h = (a ^ seed) * 32'h9E3779B1;
    return h[23:16];
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a, input int nb);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < nb; i++) w[i*8 +: 8] = mem_byte(a + 32'(i));
    return w;
  endfunction

  // Reference: gather the addressed bytes, then extend as the load type demands.
  task automatic ref_load(input int d, input logic [31:0] addr, input logic [2:0] typ,
                          output logic [63:0] data, output bit emis, output int nreads,
                          output logic [31:0] a0, output logic [31:0] a1);
    int xlen, nb, nbytes, off;
    bit sgn;
    logic [63:0] v;
    xlen = (d == 2) ? 64 : 32;
    nb   = xlen / 8;
    case (typ)
      3'd0: begin nbytes = 1; sgn = 1; end
      3'd1: begin nbytes = 2; sgn = 1; end
      3'd3: begin nbytes = (xlen == 64) ? 8 : 4; sgn = 1; end
      3'd4: begin nbytes = 1; sgn = 0; end
      3'd5: begin nbytes = 2; sgn = 0; end
      3'd6: begin nbytes = 4; sgn = 0; end
      default: begin nbytes = 4; sgn = 1; end
    endcase
    off  = int'(addr % 32'(nb));
    a0   = addr - 32'(off);
    a1   = a0 + 32'(nb);
    data = '0;
    emis = 0;
    if (off + nbytes > nb && d == 1) begin
      emis = 1; nreads = 0;
    end else begin
      nreads = (off + nbytes > nb) ? 2 : 1;
      v = '0;
      for (int i = 0; i < nbytes; i++) v[i*8 +: 8] = mem_byte(addr + 32'(i));
      if (sgn && nbytes * 8 < xlen && v[nbytes*8-1]) v = v | ({64{1'b1}} << (nbytes * 8));
      if (xlen == 32) v[63:32] = '0;
      data = v;
    end
  endtask

  // Drives one load through the selected instance and plays the memory side.
  task automatic run_load(input int d, input logic [31:0] addr, input logic [2:0] typ,
                          input int gd, input int rd, input bit fixed,
                          input logic [63:0] fw0, input logic [63:0] fw1, input bit noise,
                          output logic [63:0] data, output bit omis, output int nreads,
                          output logic [31:0] ra0, output logic [31:0] ra1,
                          output int lat, output bit tmo, output bit unstable);
    int gcnt, rcnt;
    bit wait_rv, seen;
    logic [31:0] cur;
    data = '0; omis = 0; nreads = 0; ra0 = '0; ra1 = '0; lat = 0; tmo = 0; unstable = 0;
    gcnt = 0; rcnt = 0; wait_rv = 0; seen = 0; cur = '0;
    sel = d;
    @(negedge clk);
    for (int i = 0; i < 50 && !o_ready; i++) @(negedge clk);
    req_addr = addr; req_type = typ; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (lat < 200) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (o_rsp_valid) begin
        data = o_rsp_data; omis = o_rsp_mis;
        return;
      end
      if (wait_rv) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = fixed ? ((nreads == 1) ? fw0 : fw1) : mem_word(cur, (d == 2) ? 8 : 4);
          wait_rv    = 0;
        end else rcnt--;
      end else if (o_mem_req) begin
        if (!seen) begin
          seen = 1; cur = o_mem_addr; gcnt = 0;
          if (nreads == 0) ra0 = cur; else ra1 = cur;
        end else if (o_mem_addr !== cur) unstable = 1;
        if (gcnt == gd) begin
          mem_gnt = 1'b1; nreads++; seen = 0; wait_rv = 1; rcnt = rd;
        end else begin
          gcnt++;
          if (noise) mem_rvalid = 1'b1;
        end
      end
      @(negedge clk);
      lat++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tmo = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      checks++;
      if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_addr !== 32'h0 ||
          o_rsp_valid !== 1'b0 || o_rsp_data !== 64'h0 || o_rsp_mis !== 1'b0) begin
        errors++;
        $display("FAIL reset d%0d: ready=%b req=%b addr=%h vld=%b data=%h mis=%b, want 1 0 0 0 0 0",
                 d, o_ready, o_mem_req, o_mem_addr, o_rsp_valid, o_rsp_data, o_rsp_mis);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0] data, held; bit m, tmo, uns; int nr, lat; logic [31:0] a0, a1;
    // aligned LB with sign extension
    run_load(0, 32'h1003, 3'd0, 0, 0, 1, 64'h80FF_FF00, 64'h0, 0, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || data !== 64'hFFFF_FF80 || m !== 0 || nr != 1 || a0 !== 32'h1000 || lat != 3) begin
      errors++;
      $display("FAIL lb_aligned: tmo=%0d data=%h mis=%b reads=%0d a0=%h lat=%0d, want data=ffffff80 reads=1 a0=1000 lat=3",
               tmo, data, m, nr, a0, lat);
    end
    held = o_rsp_data;
    @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rsp_data !== held || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_pulse: vld=%b data=%h ready=%b, want vld=0 data=%h ready=1", o_rsp_valid, o_rsp_data, o_ready, held);
    end
    // split LW across two words
    run_load(0, 32'h2006, 3'd2, 0, 0, 1, 64'hAABB_CCDD, 64'h1122_3344, 0, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || data !== 64'h3344_AABB || nr != 2 || a0 !== 32'h2004 || a1 !== 32'h2008 || lat != 5) begin
      errors++;
      $display("FAIL lw_split: tmo=%0d data=%h reads=%0d a0=%h a1=%h lat=%0d, want 3344aabb 2 2004 2008 5",
               tmo, data, nr, a0, a1, lat);
    end
    // misaligned with splitting disabled
    run_load(1, 32'h0003, 3'd1, 0, 0, 1, 64'h0, 64'h0, 0, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || data !== 64'h0 || m !== 1 || nr != 0 || lat != 1) begin
      errors++;
      $display("FAIL lh_nosplit: tmo=%0d data=%h mis=%b reads=%0d lat=%0d, want 0 1 0 1", tmo, data, m, nr, lat);
    end
    // 64-bit LWU and LW
    run_load(2, 32'h10, 3'd6, 0, 0, 1, 64'h0000_0000_F000_0001, 64'h0, 0, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || data !== 64'h0000_0000_F000_0001 || a0 !== 32'h10) begin
      errors++;
      $display("FAIL lwu64: tmo=%0d data=%h a0=%h, want 00000000f0000001 a0=10", tmo, data, a0);
    end
    run_load(2, 32'h10, 3'd2, 0, 0, 1, 64'h0000_0000_F000_0001, 64'h0, 0, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || data !== 64'hFFFF_FFFF_F000_0001) begin
      errors++;
      $display("FAIL lw64: tmo=%0d data=%h, want fffffffff0000001", tmo, data);
    end
  endtask

  task automatic test_grant_stall();
    logic [63:0] data, edata; bit m, em, tmo, uns; int nr, enr, lat; logic [31:0] a0, a1, e0, e1;
    ref_load(0, 32'h3000_0040, 3'd2, edata, em, enr, e0, e1);
    run_load(0, 32'h3000_0040, 3'd2, 4, 1, 0, 64'h0, 64'h0, 1, data, m, nr, a0, a1, lat, tmo, uns);
    checks++;
    if (tmo || uns || data !== edata || a0 !== e0 || lat != 3 + 4 + 1) begin
      errors++;
      $display("FAIL gnt_stall: tmo=%0d unstable=%0d data=%h a0=%h lat=%0d, want data=%h a0=%h lat=8",
               tmo, uns, data, a0, lat, edata, e0);
    end
  endtask

  task automatic test_reset_midflight();
    bit saw;
    sel = 0;
    @(negedge clk);
    req_addr = 32'h2006; req_type = 3'd2; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hAABB_CCDD;
    @(negedge clk); mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort: ready=%b req=%b, want 0 0", o_ready, o_mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_abort: ready=%b req=%b addr=%h, want 1 0 0", o_ready, o_mem_req, o_mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (o_rsp_valid) saw = 1;
    end
    checks++;
    if (saw || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid: rsp_seen=%0d ready=%b, want 0 1", saw, o_ready);
    end
  endtask

  task automatic test_random();
    logic [63:0] data, edata; bit m, em, tmo, uns; int nr, enr, lat, elat, gd, rd;
    logic [31:0] a0, a1, e0, e1, addr; logic [2:0] typ;
    for (int n = 0; n < 150; n++) begin
      int d;
      d    = n % 3;
      addr = $urandom;
      if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      typ  = 3'($urandom_range(0, 7));
      gd   = $urandom_range(0, 2);
      rd   = $urandom_range(0, 2);
      ref_load(d, addr, typ, edata, em, enr, e0, e1);
      run_load(d, addr, typ, gd, rd, 0, 64'h0, 64'h0, n[0], data, m, nr, a0, a1, lat, tmo, uns);
      elat = em ? 1 : 3 + gd + rd + ((enr == 2) ? 2 + gd + rd : 0);
      checks++;
      if (tmo || uns || data !== edata || m !== em || nr != enr || lat != elat ||
          (enr >= 1 && a0 !== e0) || (enr == 2 && a1 !== e1)) begin
        errors++;
        $display("FAIL rand d%0d addr=%h type=%0d: tmo=%0d uns=%0d data=%h mis=%b reads=%0d a0=%h a1=%h lat=%0d, want data=%h mis=%b reads=%0d a0=%h a1=%h lat=%0d",
                 d, addr, typ, tmo, uns, data, m, nr, a0, a1, lat, edata, em, enr, e0, e1, elat);
      end
    end
  endtask

  initial begin
    seed = $urandom;
    sel = 0; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    req_addr = '0; req_type = '0; mem_rdata = '0;
    test_reset();
    test_directed();
    test_grant_stall();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
